// File: rtl/seg7_rx_decodificador.sv
// Snoops a multiplexed 4-digit active-low 7-segment bus and recovers the hex digit on each position.
// Optional macro SEG7RX_DP_CAPTURE_EN adds the per-digit decimal-point output puntos.
`timescale 1ns/1ps
module seg7_rx_decodificador #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  prenderDisplay,
  input  logic [6:0]  ledsAhastaG,
  input  logic        DP,
  output logic [15:0] digitos,
  output logic [3:0]  valido,
  output logic        nuevo_dato,
  output logic        error_patron
`ifdef SEG7RX_DP_CAPTURE_EN
  ,
  output logic [3:0]  puntos
`endif
);

  typedef enum logic [1:0] {ESPERA, ESTABILIZA, CAPTURADO} state_t;

  state_t      state;
  logic [10:0] sync1, sync2, prev_s;
  logic [7:0]  stab_cnt;
  logic [15:0] idle_cnt;
  logic        multi_q;

  logic [3:0]  an_s, low;
  logic [6:0]  seg_s;
  logic        one_hot, all_high, multi, changed, stable_ok, timeout_hit;
  logic [1:0]  idx;
  logic [4:0]  dec;
  logic [3:0]  cur_nib;
  logic        pt_chg;

`ifdef SEG7RX_DP_CAPTURE_EN
  logic dp1, dp2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp1 <= 1'b1;
      dp2 <= 1'b1;
    end else begin
      dp1 <= DP;
      dp2 <= dp1;
    end
  end
  assign pt_chg = puntos[idx] != ~dp2;
`else
  logic unused_dp;
  assign unused_dp = DP;
  assign pt_chg    = 1'b0;
`endif

  // Returns {legal, nibble}; blank and any unlisted code decode as illegal.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001101: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {prenderDisplay, ledsAhastaG};
      sync2 <= sync1;
    end
  end

  assign an_s     = sync2[10:7];
  assign seg_s    = sync2[6:0];
  assign low      = ~an_s;
  assign one_hot  = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign all_high = (low == 4'd0);
  assign multi    = !all_high && !one_hot;
  assign changed  = sync2 != prev_s;
  // stab_cnt lags the run of identical samples by one, hence the -1.
  assign stable_ok   = !changed && (stab_cnt >= 8'(STABLE_CYCLES - 1));
  assign timeout_hit = all_high && (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign dec         = decode(seg_s);
  assign cur_nib     = digitos[{idx, 2'b00} +: 4];

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (low[i]) idx = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_s   <= '1;
      stab_cnt <= '0;
      idle_cnt <= '0;
      multi_q  <= 1'b0;
    end else begin
      prev_s  <= sync2;
      multi_q <= multi;
      if (changed)
        stab_cnt <= '0;
      else if (stab_cnt != 8'hFF)
        stab_cnt <= stab_cnt + 8'd1;
      if (!all_high)
        idle_cnt <= '0;
      else if (idle_cnt != 16'(TIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ESPERA;
      digitos      <= '0;
      valido       <= '0;
      nuevo_dato   <= 1'b0;
      error_patron <= 1'b0;
`ifdef SEG7RX_DP_CAPTURE_EN
      puntos       <= '0;
`endif
    end else begin
      nuevo_dato   <= 1'b0;
      error_patron <= multi && !multi_q;
      case (state)
        ESPERA: begin
          if (one_hot) state <= ESTABILIZA;
        end
        ESTABILIZA: begin
          if (!one_hot) begin
            state <= ESPERA;
          end else if (stable_ok) begin
            state <= CAPTURADO;
`ifdef SEG7RX_DP_CAPTURE_EN
            puntos[idx] <= ~dp2;
`endif
            if (dec[4]) begin
              digitos[{idx, 2'b00} +: 4] <= dec[3:0];
              valido[idx] <= 1'b1;
              nuevo_dato  <= (cur_nib != dec[3:0]) || !valido[idx] || pt_chg;
            end else begin
              valido[idx]  <= 1'b0;
              error_patron <= 1'b1;
              nuevo_dato   <= valido[idx] || pt_chg;
            end
          end
        end
        CAPTURADO: begin
          if (!one_hot)
            state <= ESPERA;
          else if (changed)
            state <= ESTABILIZA;
        end
        default: state <= ESPERA;
      endcase
      // Only possible with all anodes high, so never overlaps a capture.
      if (timeout_hit) begin
        valido <= '0;
`ifdef SEG7RX_DP_CAPTURE_EN
        puntos     <= '0;
        nuevo_dato <= (valido != 4'd0) || (puntos != 4'd0);
`else
        nuevo_dato <= valido != 4'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg7_rx_decodificador.sv
// Randomized self-checking bench for seg7_rx_decodificador against a run-length reference model.
`timescale 1ns/1ps
module tb_seg7_rx_decodificador;
  localparam int unsigned STABLE  = 4;
  localparam int unsigned TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  prenderDisplay;
  logic [6:0]  ledsAhastaG;
  logic        DP;
  logic [15:0] digitos;
  logic [3:0]  valido;
  logic        nuevo_dato, error_patron;
`ifdef SEG7RX_DP_CAPTURE_EN
  logic [3:0]  puntos;
`endif

  always #5 clk = ~clk;

  seg7_rx_decodificador #(
    .STABLE_CYCLES(STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .prenderDisplay(prenderDisplay),
    .ledsAhastaG(ledsAhastaG),
    .DP(DP),
    .digitos(digitos),
    .valido(valido),
    .nuevo_dato(nuevo_dato),
    .error_patron(error_patron)
`ifdef SEG7RX_DP_CAPTURE_EN
    ,
    .puntos(puntos)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nuevo_cnt, err_cnt;

  // Segment code shown for each hex value (index = value).
  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference model state: pin history, run lengths of the synchronised view, expected outputs.
  logic [11:0] hist [$];
  logic [10:0] last_d;
  int          run, idle_run;
  bit          last_multi;
  logic [3:0]  m_dig [4];
  bit          m_val [4];
  bit          m_pt  [4];
  bit          exp_nuevo, exp_err;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    last_d     = '1;
    run        = 0;
    idle_run   = 0;
    last_multi = 0;
    exp_nuevo  = 0;
    exp_err    = 0;
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = '0;
      m_val[i] = 0;
      m_pt[i]  = 0;
    end
  endtask

  // Pins seen at an edge reach the decision logic two edges later.
  task automatic model_edge(input logic [11:0] pins);
    logic [11:0] d;
    logic [3:0]  lo;
    int          nlow, pos, val;
    bit          any;
    hist.push_back(pins);
    if (hist.size() > 3) void'(hist.pop_front());
    d    = (hist.size() == 3) ? hist[0] : 12'hFFF;
    lo   = ~d[10:7];
    nlow = $countones(lo);
    if (d[10:0] == last_d) run++;
    else run = 1;
    last_d    = d[10:0];
    exp_nuevo = 0;
    exp_err   = (nlow >= 2) && !last_multi;
    last_multi = (nlow >= 2);
    idle_run  = (nlow == 0) ? idle_run + 1 : 0;
    if (nlow == 1 && run == STABLE + 1) begin
      pos = 0;
      for (int i = 0; i < 4; i++) if (lo[i]) pos = i;
      val = -1;
      for (int j = 0; j < 16; j++) if (seg_tab[j] == d[6:0]) val = j;
      if (val >= 0) begin
        if (m_dig[pos] != 4'(val) || !m_val[pos]) exp_nuevo = 1;
        m_dig[pos] = 4'(val);
        m_val[pos] = 1;
      end else begin
        exp_err = 1;
        if (m_val[pos]) exp_nuevo = 1;
        m_val[pos] = 0;
      end
`ifdef SEG7RX_DP_CAPTURE_EN
      if (m_pt[pos] != !d[11]) exp_nuevo = 1;
      m_pt[pos] = !d[11];
`endif
    end
    if (idle_run == TIMEOUT) begin
      any = 0;
      for (int i = 0; i < 4; i++) begin
`ifdef SEG7RX_DP_CAPTURE_EN
        if (m_pt[i]) any = 1;
        m_pt[i] = 0;
`endif
        if (m_val[i]) any = 1;
        m_val[i] = 0;
      end
      if (any) exp_nuevo = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("digitos", digitos, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    check_eq("valido", 16'(valido), 16'({m_val[3], m_val[2], m_val[1], m_val[0]}));
    check_eq("nuevo_dato", 16'(nuevo_dato), 16'(exp_nuevo));
    check_eq("error_patron", 16'(error_patron), 16'(exp_err));
`ifdef SEG7RX_DP_CAPTURE_EN
    check_eq("puntos", 16'(puntos), 16'({m_pt[3], m_pt[2], m_pt[1], m_pt[0]}));
`endif
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    prenderDisplay = an;
    ledsAhastaG    = seg;
    DP             = dp;
    @(posedge clk);
    model_edge({dp, an, seg});
    #1;
    nuevo_cnt += 32'(nuevo_dato);
    err_cnt   += 32'(error_patron);
    compare_all();
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    for (int k = 0; k < n; k++) step(an, seg, dp);
  endtask

  task automatic scan(input logic dp1);
    logic [3:0] codes [4];
    codes = '{4'h1, 4'hA, 4'h7, 4'hF};
    for (int k = 0; k < 4; k++)
      hold(~(4'b0001 << k), seg_tab[codes[k]], (k == 1) ? dp1 : 1'b1, 20);
  endtask

  initial begin
    logic [3:0] an;
    logic [6:0] seg;
    int         dur, r;

    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      prenderDisplay = 4'($urandom);
      ledsAhastaG    = 7'($urandom);
      DP             = 1'($urandom);
      @(posedge clk);
      #1;
      check_eq("rst_digitos", digitos, 16'h0000);
      check_eq("rst_valido", 16'(valido), 16'h0000);
      check_eq("rst_pulses", 16'({nuevo_dato, error_patron}), 16'h0000);
    end
    prenderDisplay = 4'hF;
    ledsAhastaG    = 7'h7F;
    DP             = 1'b1;
    rst_n          = 1'b1;
    nuevo_cnt = 0;
    err_cnt   = 0;
    hold(4'hF, 7'h7F, 1'b1, 100);
    check_eq("idle_nuevo", 16'(nuevo_cnt), 16'd0);

    // Single digit and its capture latency.
    nuevo_cnt = 0;
    hold(4'b1110, 7'b0010010, 1'b1, 6);
    check_eq("lat_before", 16'(valido), 16'h0000);
    step(4'b1110, 7'b0010010, 1'b1);
    check_eq("lat_at7", 16'(valido), 16'h0001);
    hold(4'b1110, 7'b0010010, 1'b1, 3);
    check_eq("single_dig", 16'(digitos[3:0]), 16'h0002);
    check_eq("single_nuevo", 16'(nuevo_cnt), 16'd1);

    scan(1'b1);
    check_eq("scan_digitos", digitos, 16'hF7A1);
    check_eq("scan_valido", 16'(valido), 16'h000F);
    nuevo_cnt = 0;
    scan(1'b1);
    check_eq("rescan_nuevo", 16'(nuevo_cnt), 16'd0);

    // Glitch of 4 too short to capture, then 3 held.
    hold(4'b1101, 7'b1001100, 1'b1, 3);
    hold(4'b1101, 7'b0000110, 1'b1, 12);
    check_eq("glitch_dig", 16'(digitos[7:4]), 16'h0003);

    hold(4'b1011, 7'b0100100, 1'b1, 10);
    nuevo_cnt = 0;
    err_cnt   = 0;
    hold(4'b1011, 7'b1111111, 1'b1, 10);
    check_eq("blank_valido", 16'(valido), 16'h000B);
    check_eq("blank_err", 16'(err_cnt), 16'd1);
    check_eq("blank_nuevo", 16'(nuevo_cnt), 16'd1);
    err_cnt = 0;
    hold(4'b1100, 7'b0000110, 1'b1, 10);
    check_eq("multi_err", 16'(err_cnt), 16'd1);
    check_eq("multi_digitos", digitos, 16'hF531);

    scan(1'b0);
`ifdef SEG7RX_DP_CAPTURE_EN
    check_eq("dp_puntos", 16'(puntos), 16'h0002);
`endif
    nuevo_cnt = 0;
    hold(4'hF, 7'h7F, 1'b1, 60);
    check_eq("timeout_valido", 16'(valido), 16'h0000);
    check_eq("timeout_nuevo", 16'(nuevo_cnt), 16'd1);
    check_eq("timeout_digitos", digitos, 16'hF7A1);

    // Random patterns with random hold lengths.
    for (int s = 0; s < 200; s++) begin
      r   = int'($urandom_range(0, 9));
      dur = int'($urandom_range(1, 12));
      if (r <= 6)      an = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 7) an = 4'hF;
      else             an = 4'($urandom);
      if ($urandom_range(0, 9) < 7) seg = seg_tab[$urandom_range(0, 15)];
      else                          seg = 7'($urandom);
      if (r == 7 && $urandom_range(0, 1) == 1) dur = int'($urandom_range(45, 60));
      hold(an, seg, 1'($urandom), dur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_rx_decodificador.md
Name: seg7_rx_decodificador

Overview:
Receiving end of the multiplexed 4-digit 7-segment display bus: snoops the active-low anode and segment lines driven toward the board display and recovers the hex digit shown on each position. It provides per-digit valid flags, an error pulse on illegal patterns, and a pulse when any digit changes. Used for loopback self-test of the display path and for driving a shadow copy of the display onto another interface.

Parameters:
STABLE_CYCLES, 4, consecutive identical synced samples required before a digit is captured (range 1..255)
TIMEOUT_CYCLES, 65535, consecutive cycles with all anodes high before all valid flags clear (range 1..65535)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
prenderDisplay  in  4  anodes, active-low; bit0 = rightmost digit
ledsAhastaG  in  7  segments, active-low; bit6=A ... bit0=G
DP  in  1  decimal point, active-low
digitos  out  16  recovered digits; nibble i = anode i
valido  out  4  digit i holds a legal captured value
nuevo_dato  out  1  one-cycle pulse: a digit value or valid bit changed
error_patron  out  1  one-cycle pulse: illegal pattern or multiple anodes low

Behaviour:
- Reset (async, rst_n=0): digitos=16'h0000, valido=4'b0000, nuevo_dato=0, error_patron=0, sync flops all 1s, counters 0, FSM=ESPERA. Release of reset is synchronous to clk.
- Inputs pass through a 2-flop synchroniser. All decisions use the second stage ("synced").
- Legal decode table (segments → nibble):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001101→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→B
  - 0110001→C, 1000010→D, 0110000→E, 0111000→F
  - Any other code is illegal. 1111111 (blank) is illegal when an anode is active.
- Stability counter: cleared when synced {anode, seg} differs from the previous synced sample; otherwise increments, saturating at 255.
- FSM:
  - ESPERA: synced anodes not one-hot-low → stay.
    - All high: idle counter increments.
    - Two or more low: pulse error_patron once on entry to that condition; no capture.
    - Exactly one low → ESTABILIZA.
  - ESTABILIZA: wait for stability counter to show STABLE_CYCLES consecutive identical samples, then capture → CAPTURADO.
    - Any input change restarts the count.
    - Anode no longer one-hot → ESPERA.
  - CAPTURADO: hold until synced {anode, seg} changes → ESTABILIZA (or ESPERA if not one-hot). No re-capture of an unchanged pattern.
- Capture of anode i, registered on the next edge:
  - Legal code: nibble i ← decoded value, valido[i] ← 1. nuevo_dato=1 if the nibble or valido[i] changed.
  - Illegal code: valido[i] ← 0, nibble i unchanged, error_patron=1. nuevo_dato=1 if valido[i] was 1.
- Latency: input change at pins to output update = 2 + STABLE_CYCLES + 1 clk edges (7 at defaults).
- Timeout:
  - Idle counter clears whenever any anode is low.
  - When it reaches TIMEOUT_CYCLES: valido ← 0000; nuevo_dato pulses if valido was nonzero; digitos retained.
  - Counter saturates; no repeated pulses.
- DP ignored unless the optional feature is compiled in.
- Simultaneous events: a capture and a timeout cannot coincide (mutually exclusive by anode state). error_patron and nuevo_dato may pulse in the same cycle.

Optional Feature:
SEG7RX_DP_CAPTURE_EN
- Defined: adds output puntos[3:0], reset 0000. On every capture of anode i, puntos[i] ← ~DP(synced). A change in puntos[i] also pulses nuevo_dato. Timeout clears puntos.
- Undefined: no puntos port; DP input is unconnected internally (kept in the port list for pin compatibility).

Test Plan:
- Reset: hold rst_n=0 with random inputs → digitos=0000, valido=0000, no pulses; release and drive anodes=1111 for 100 cycles → outputs unchanged.
- Single digit: anodes=1110, seg=0010010 held 10 cycles → after 7 edges digitos[3:0]=2, valido=0001, nuevo_dato pulses exactly once.
- Full scan: cycle anodes 1110/1101/1011/0111 every 20 cycles with codes for 1, A, 7, F → digitos=16'hF7A1, valido=1111; a second identical scan gives no nuevo_dato.
- Glitch rejection: anodes=1101, seg=1001100 for 3 cycles, then 0000110 held → only 3 captured in digitos[7:4]; 4 never appears.
- Errors: anodes=1011, seg=1111111 held after a prior legal 5 → valido[2]=0, error_patron and nuevo_dato pulse; anodes=1100 → single error_patron, digitos unchanged.
- Timeout (TIMEOUT_CYCLES=50): after full capture, anodes=1111 for 50 cycles → valido=0000 and one nuevo_dato pulse; with SEG7RX_DP_CAPTURE_EN, DP=0 on digit 1 beforehand gives puntos=0010, cleared on timeout.
